// File: rtl/conv_output_writer.sv
// Buffers adder-tree results in a small FIFO and writes them to the output BRAM
// in raster order whenever the shared BRAM port is granted.
module conv_output_writer #(
  parameter int          OUT_ROWS   = 5,
  parameter int          OUT_COLS   = 5,
  parameter logic [17:0] BASE_ADDR  = 18'd0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [15:0]                   in_data,
  input  logic                          bram_grant,
  output logic [17:0]                   Output_write_addr,
  output logic [15:0]                   Output_write_data,
  output logic [1:0]                    Output_BRAM_we,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          drop_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_COLS - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  // S_LAST is the cycle the final write is on the port; the FIFO is flushed then.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic [17:0]   addr_cnt_reg;

  logic run_active, start_accept, pop, push, flush, drop_set, last_pix;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (pop && last_pix) state_next = S_LAST;
      S_LAST:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    run_active   = (state_reg == S_RUN);
    start_accept = (state_reg == S_IDLE) && start;
    busy         = (state_reg == S_RUN) || (state_reg == S_LAST);
    frame_done   = (state_reg == S_DONE);
  end

  assign pop      = run_active && (count_reg != '0) && bram_grant;
  assign push     = run_active && in_valid && ((count_reg != LEVEL_FULL) || pop);
  assign flush    = start_accept || (state_reg == S_LAST);
  assign last_pix = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
  // A result arriving alongside the accepted start is discarded silently.
  assign drop_set = (in_valid && !push && !start_accept) ||
                    ((state_reg == S_LAST) && (count_reg != '0));
  assign fifo_level = count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_reg           <= '0;
      col_reg           <= '0;
      addr_cnt_reg      <= BASE_ADDR;
      Output_write_addr <= '0;
      Output_write_data <= '0;
      Output_BRAM_we    <= 2'b00;
    end else begin
      Output_BRAM_we <= pop ? 2'b11 : 2'b00;
      if (start_accept) begin
        row_reg      <= '0;
        col_reg      <= '0;
        addr_cnt_reg <= BASE_ADDR;
      end else if (pop) begin
        Output_write_data <= mem[rd_ptr_reg];
        Output_write_addr <= addr_cnt_reg;
        addr_cnt_reg      <= addr_cnt_reg + 18'd1;
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          drop_err <= 1'b0;
    else if (start_accept) drop_err <= 1'b0;
    else if (drop_set)     drop_err <= 1'b1;
  end

endmodule
